// File: rtl/seg7_rx_pkg.sv
// Shared definitions for the 7-segment receive monitor.
//   SEG_PAT : active-high segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
//   state_e : monitor FSM states HUNT / SYNC / LOCKED
package seg7_rx_pkg;

    localparam logic [6:0] SEG_PAT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder.
//   pattern_i : active-high segment pattern {g,f,e,d,c,b,a}
//   valid_o   : pattern matches one of the 16 hex glyphs
//   value_o   : decoded hex value (0 when no match)
module seg7_decode
    import seg7_rx_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       valid_o,
    output logic [3:0] value_o
);

    always_comb begin
        valid_o = 1'b0;
        value_o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (!valid_o && pattern_i == SEG_PAT[i]) begin
                valid_o = 1'b1;
                value_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_rx_monitor.sv
// Receive-side monitor for the 1 Hz counter-to-display link. Samples the
// active-low segment bus and overflow flag, decodes the digit, checks the
// 0..9 count sequence with wrap, and derives a tens digit from wraps seen
// while locked.
//   clk_1Hz     : sample clock, rising edge
//   rst_n       : asynchronous active-low reset
//   seg_in      : {g,f,e,d,c,b,a}, 0 = segment lit
//   overflow_in : high while the sender shows 9
//   digit       : last legally decoded digit
//   digit_valid : last sample matched a legal glyph
//   tens        : wrap count 0..9
//   locked      : FSM in LOCKED
//   err         : error flag (pulse, or sticky with SEG7_RX_STICKY_ERR_EN)
//   err_cnt     : saturating count of erroneous samples
// Build option: define SEG7_RX_STICKY_ERR_EN to make err sticky until reset.
module seg7_rx_monitor
    import seg7_rx_pkg::*;
#(
    parameter int unsigned LOCK_CNT  = 3,
    parameter int unsigned ERR_LIMIT = 2,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk_1Hz,
    input  logic             rst_n,
    input  logic [6:0]       seg_in,
    input  logic             overflow_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic [3:0]       tens,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned EC_W  = $clog2(ERR_LIMIT + 1);

    logic [6:0]       seg_on;
    logic             dec_valid;
    logic [3:0]       dec_value;

    state_e           state_q;
    logic [3:0]       prev_q;
    logic [RUN_W-1:0] run_q;
    logic [EC_W-1:0]  errs_q;
    logic [3:0]       digit_q;
    logic             valid_q;
    logic [3:0]       tens_q, tens_d;
    logic             locked_q;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [3:0]       seq_exp;
    logic             samp_err, seq_err, any_err;

    assign seg_on = ~seg_in;

    seg7_decode u_decode (
        .pattern_i (seg_on),
        .valid_o   (dec_valid),
        .value_o   (dec_value)
    );

    always_comb begin
        seq_exp   = (prev_q == 4'd9) ? 4'd0 : prev_q + 4'd1;
        samp_err  = !dec_valid || (dec_value > 4'd9) ||
                    (overflow_in != (dec_value == 4'd9));
        // Sequence is only meaningful once a reference digit exists.
        seq_err   = (state_q != HUNT) && (dec_value != seq_exp);
        any_err   = samp_err || seq_err;
        err_cnt_d = (any_err && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
        tens_d    = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
`ifdef SEG7_RX_STICKY_ERR_EN
        err_d     = err_q || any_err;
`else
        err_d     = any_err;
`endif
    end

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            prev_q    <= '0;
            run_q     <= '0;
            errs_q    <= '0;
            digit_q   <= '0;
            valid_q   <= 1'b0;
            tens_q    <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            valid_q   <= dec_valid;
            if (dec_valid) digit_q <= dec_value;

            case (state_q)
                HUNT: begin
                    if (!any_err) begin
                        state_q <= SYNC;
                        run_q   <= '0;
                        prev_q  <= dec_value;
                    end
                end
                SYNC: begin
                    if (any_err) begin
                        state_q <= HUNT;
                    end else begin
                        prev_q <= dec_value;
                        run_q  <= run_q + 1'b1;
                        if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                            errs_q   <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        // Isolated errors are tolerated; prev stays on the last good digit.
                        if (errs_q == EC_W'(ERR_LIMIT - 1)) begin
                            state_q  <= HUNT;
                            locked_q <= 1'b0;
                            errs_q   <= '0;
                        end else begin
                            errs_q <= errs_q + 1'b1;
                        end
                    end else begin
                        errs_q <= '0;
                        prev_q <= dec_value;
                        if (prev_q == 4'd9) tens_q <= tens_d;
                    end
                end
                default: begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign tens        = tens_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_seg7_rx_monitor.sv
module tb_seg7_rx_monitor;

`ifdef SEG7_RX_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk_1Hz;
    logic       rst_n;
    logic [6:0] seg_in;
    logic       overflow_in;
    logic [3:0] digit;
    logic       digit_valid;
    logic [3:0] tens;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int e_cnt  = 0;
    bit seen   = 1'b0;

    logic [6:0] pat [16];

    seg7_rx_monitor #(
        .LOCK_CNT  (3),
        .ERR_LIMIT (2),
        .ERR_W     (8)
    ) dut (
        .clk_1Hz     (clk_1Hz),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .overflow_in (overflow_in),
        .digit       (digit),
        .digit_valid (digit_valid),
        .tens        (tens),
        .locked      (locked),
        .err         (err),
        .err_cnt     (err_cnt)
    );

    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected err given whether the sample just taken was erroneous.
    function automatic int exp_err(input bit now_err);
        if (now_err) seen = 1'b1;
        return STICKY ? int'(seen) : int'(now_err);
    endfunction

    task automatic drive_raw(input logic [6:0] seg, input logic ovf);
        seg_in      = seg;
        overflow_in = ovf;
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic send(input int d);
        logic [6:0] p;
        p = pat[d];
        drive_raw(~p, d == 9);
    endtask

    initial begin
        pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F;
        pat[4] = 7'h66; pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07;
        pat[8] = 7'h7F; pat[9] = 7'h67; pat[10] = 7'h77; pat[11] = 7'h7C;
        pat[12] = 7'h39; pat[13] = 7'h5E; pat[14] = 7'h79; pat[15] = 7'h71;

        rst_n = 1'b0;
        seg_in = 7'h7F;
        overflow_in = 1'b0;
        @(posedge clk_1Hz);
        #1;
        check("rst_digit", digit, 0);
        check("rst_valid", digit_valid, 0);
        check("rst_tens", tens, 0);
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_errcnt", err_cnt, 0);
        rst_n = 1'b1;

        // 1: lock after three correct increments
        send(0);
        check("t1_valid0", digit_valid, 1);
        check("t1_lock0", locked, 0);
        send(1);
        send(2);
        check("t1_lock2", locked, 0);
        send(3);
        check("t1_lock3", locked, 1);
        check("t1_digit3", digit, 3);
        check("t1_errcnt", err_cnt, 0);
        check("t1_err", err, 0);

        // 2: tens counts wraps, ten wraps return it to 0
        for (int d = 4; d <= 9; d++) send(d);
        check("t2_tens_at9", tens, 0);
        check("t2_digit9", digit, 9);
        send(0);
        check("t2_tens_1", tens, 1);
        for (int w = 1; w <= 9; w++) begin
            for (int d = 1; d <= 9; d++) send(d);
            send(0);
            check($sformatf("t2_tens_w%0d", w), tens, (1 + w) % 10);
        end
        check("t2_locked", locked, 1);
        check("t2_errcnt", err_cnt, 0);
        for (int d = 1; d <= 4; d++) send(d);

        // 3: out-of-sequence 8 tolerated once, illegal glyph then drops lock
        drive_raw(7'h00, 1'b0);
        e_cnt++;
        check("t3_digit8", digit, 8);
        check("t3_valid8", digit_valid, 1);
        check("t3_errcnt1", err_cnt, e_cnt);
        check("t3_locked1", locked, 1);
        check("t3_err1", err, exp_err(1'b1));
        drive_raw(7'h55, 1'b0);
        e_cnt++;
        check("t3_valid55", digit_valid, 0);
        check("t3_digit_hold", digit, 8);
        check("t3_errcnt2", err_cnt, e_cnt);
        check("t3_locked2", locked, 0);
        check("t3_err2", err, exp_err(1'b1));
        drive_raw(7'h08, 1'b0);  // glyph A: legal pattern, illegal digit
        e_cnt++;
        check("t3_digitA", digit, 10);
        check("t3_validA", digit_valid, 1);
        check("t3_errcntA", err_cnt, e_cnt);

        // 4: 9 without overflow is a sample error; err pulses one cycle
        begin
            logic [6:0] p9;
            p9 = pat[9];
            drive_raw(~p9, 1'b0);
        end
        e_cnt++;
        check("t4_errcnt", err_cnt, e_cnt);
        check("t4_err_hi", err, exp_err(1'b1));
        send(5);
        check("t4_err_lo", err, exp_err(1'b0));
        check("t4_errcnt_hold", err_cnt, e_cnt);
        send(6);
        send(7);
        check("t4_lock_pre", locked, 0);
        send(8);
        check("t4_relock", locked, 1);

        // 5: stalled digit is a sequence error; good sample resets the run
        send(9);
        send(0);
        check("t5_tens1", tens, 1);
        for (int d = 1; d <= 5; d++) send(d);
        send(5);
        e_cnt++;
        check("t5_stall_errcnt", err_cnt, e_cnt);
        check("t5_stall_locked", locked, 1);
        check("t5_stall_err", err, exp_err(1'b1));
        send(6);
        check("t5_recover_locked", locked, 1);
        check("t5_recover_err", err, exp_err(1'b0));
        send(6);
        e_cnt++;
        check("t5_stall2_locked", locked, 1);
        check("t5_stall2_errcnt", err_cnt, e_cnt);
        send(7);
        check("t5_locked_end", locked, 1);
        send(8);
        send(9);
        send(0);
        check("t5_tens2", tens, 2);
        for (int d = 1; d <= 9; d++) send(d);
        send(0);
        check("t5_tens3", tens, 3);

        // 6: async reset mid-LOCKED, then err_cnt saturation
        #2;
        rst_n = 1'b0;
        #1;
        seen = 1'b0;
        e_cnt = 0;
        check("t6_digit", digit, 0);
        check("t6_valid", digit_valid, 0);
        check("t6_tens", tens, 0);
        check("t6_locked", locked, 0);
        check("t6_err", err, 0);
        check("t6_errcnt", err_cnt, 0);
        @(posedge clk_1Hz);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive_raw(7'h55, 1'b0);
            if (i == 253) check("t6_errcnt_254", err_cnt, 254);
        end
        check("t6_errcnt_sat", err_cnt, 255);
        check("t6_locked_end", locked, 0);
        check("t6_valid_end", digit_valid, 0);
        check("t6_err_end", err, 1);
        send(0);
        check("t6_errcnt_hold", err_cnt, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
